// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
//
// Frame-level round-robin arbiter sharing the MAC transmit path between two
// AXI-Stream byte sources. One whole frame is forwarded at a time. Frames
// shorter than MIN_FRAME_BYTES are zero-padded so that frame plus FCS reaches
// the Ethernet minimum. After each frame, an idle gap of IFG_CYCLES cycles is
// enforced before the next arbitration.
//
// Ports:
//   clock, aresetn              single clock, asynchronous active-low reset
//   saxis0_* / saxis1_*         requester byte streams (tdata/tvalid/tready/
//                               tlast/tuser, tuser = frame error flag)
//   maxis_*                     padded byte stream towards the CRC-append stage
//   grant[1:0]                  one-hot owner of the current frame, 0 when idle
//   busy                        high whenever a frame or gap is in progress
// -----------------------------------------------------------------------------
module mac_tx_arbiter #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_CYCLES      = 12,
    parameter int COUNT_WIDTH     = 11
) (
    input  logic       clock,
    input  logic       aresetn,

    input  logic [7:0] saxis0_tdata,
    input  logic       saxis0_tvalid,
    output logic       saxis0_tready,
    input  logic       saxis0_tlast,
    input  logic       saxis0_tuser,

    input  logic [7:0] saxis1_tdata,
    input  logic       saxis1_tvalid,
    output logic       saxis1_tready,
    input  logic       saxis1_tlast,
    input  logic       saxis1_tuser,

    output logic [7:0] maxis_tdata,
    output logic       maxis_tvalid,
    input  logic       maxis_tready,
    output logic       maxis_tlast,
    output logic       maxis_tuser,

    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAD,
        S_GAP
    } state_t;

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    // Count value of the byte that completes a minimum-length frame.
    localparam logic [COUNT_WIDTH-1:0] MIN_LAST  = COUNT_WIDTH'(MIN_FRAME_BYTES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [GAP_W-1:0]       GAP_LAST  =
        GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    // Where a completed frame goes: straight back to arbitration when no gap.
    localparam state_t S_DONE = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t                 state_q,      state_d;
    logic [1:0]             grant_q,      grant_d;
    logic                   last_grant_q, last_grant_d;  // index of last port served
    logic [COUNT_WIDTH-1:0] byte_count_q, byte_count_d;
    logic                   err_sticky_q, err_sticky_d;
    logic [GAP_W-1:0]       gap_count_q,  gap_count_d;

    // Granted-port view of the inputs.
    logic                   sel_port;
    logic [7:0]             sel_tdata;
    logic                   sel_tvalid;
    logic                   sel_tlast;
    logic                   sel_tuser;
    logic                   pick_port1;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   min_reached;

    assign sel_port   = grant_q[1];
    assign sel_tdata  = sel_port ? saxis1_tdata  : saxis0_tdata;
    assign sel_tvalid = sel_port ? saxis1_tvalid : saxis0_tvalid;
    assign sel_tlast  = sel_port ? saxis1_tlast  : saxis0_tlast;
    assign sel_tuser  = sel_port ? saxis1_tuser  : saxis0_tuser;

    // On a tie the port that was not served last wins.
    assign pick_port1 = (saxis0_tvalid && saxis1_tvalid) ? ~last_grant_q : saxis1_tvalid;

    // Saturating increment: once pinned at the maximum the count stays above
    // MIN_LAST, so a long frame can never fall back into the padding decision.
    assign count_inc   = (byte_count_q == COUNT_MAX) ? byte_count_q
                                                     : byte_count_q + COUNT_WIDTH'(1);
    assign min_reached = (byte_count_q >= MIN_LAST);

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        byte_count_d  = byte_count_q;
        err_sticky_d  = err_sticky_q;
        gap_count_d   = gap_count_q;
        maxis_tdata   = 8'h00;
        maxis_tvalid  = 1'b0;
        maxis_tlast   = 1'b0;
        maxis_tuser   = 1'b0;
        saxis0_tready = 1'b0;
        saxis1_tready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (saxis0_tvalid || saxis1_tvalid) begin
                    grant_d      = pick_port1 ? 2'b10 : 2'b01;
                    last_grant_d = pick_port1;
                    byte_count_d = '0;
                    err_sticky_d = 1'b0;
                    state_d      = S_DATA;
                end
            end

            S_DATA: begin
                maxis_tdata   = sel_tdata;
                maxis_tvalid  = sel_tvalid;
                maxis_tuser   = sel_tuser | err_sticky_q;
                // A short frame's final byte is sent without tlast; S_PAD ends it.
                maxis_tlast   = sel_tlast & min_reached;
                saxis0_tready = ~sel_port & maxis_tready;
                saxis1_tready =  sel_port & maxis_tready;

                if (sel_tvalid && maxis_tready) begin
                    byte_count_d = count_inc;
                    err_sticky_d = err_sticky_q | sel_tuser;
                    if (sel_tlast) begin
                        if (min_reached) begin
                            state_d     = S_DONE;
                            gap_count_d = '0;
                            grant_d     = (S_DONE == S_IDLE) ? 2'b00 : grant_q;
                        end else begin
                            state_d = S_PAD;
                        end
                    end
                end
            end

            S_PAD: begin
                // Driven purely from registered state, so stable under backpressure.
                maxis_tvalid = 1'b1;
                maxis_tuser  = err_sticky_q;
                maxis_tlast  = (byte_count_q == MIN_LAST);

                if (maxis_tready) begin
                    byte_count_d = count_inc;
                    if (byte_count_q == MIN_LAST) begin
                        state_d     = S_DONE;
                        gap_count_d = '0;
                        grant_d     = (S_DONE == S_IDLE) ? 2'b00 : grant_q;
                    end
                end
            end

            S_GAP: begin
                if (gap_count_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end else begin
                    gap_count_d = gap_count_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values of the previous cycle, independent of statement order.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;  // port 0 wins the first tie
            byte_count_q <= '0;
            err_sticky_q <= 1'b0;
            gap_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_count_q <= byte_count_d;
            err_sticky_q <= err_sticky_d;
            gap_count_q  <= gap_count_d;
        end
    end

endmodule
